// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the
// shared single-port memory. The arbiter uses the master view, the environment the slave view.
interface mem_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;

  logic        data_req;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;

  logic        mem_req;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_ok,
    input  data_req, data_sel, data_addr, data_wdata,
    output data_rdata, data_ok,
    output mem_req, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output bus_err
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_ok,
    output data_req, data_sel, data_addr, data_wdata,
    input  data_rdata, data_ok,
    input  mem_req, mem_sel, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one shared memory port with
// data priority, a bounded memory wait and a one-cycle response state.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        wait_expired;

  logic        mem_req_q;
  logic [3:0]  sel_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        inst_ok_q;
  logic        data_ok_q;
  logic        bus_err_q;

  always_comb begin
    cnt_d        = cnt_q + 8'd1;
    wait_expired = (cnt_q == WAIT_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      sel_q        <= 4'd0;
      addr_q       <= 30'd0;
      wdata_q      <= 32'd0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      // Completion pulses live for the RESP cycle only.
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          if (bus.data_req) begin
            state_q   <= DATA;
            mem_req_q <= 1'b1;
            addr_q    <= bus.data_addr[31:2];
            sel_q     <= bus.data_sel;
            wdata_q   <= bus.data_wdata;
          end else if (bus.inst_req) begin
            state_q   <= INST;
            mem_req_q <= 1'b1;
            addr_q    <= bus.inst_addr[31:2];
            sel_q     <= 4'd0;
            wdata_q   <= 32'd0;
          end
        end
        INST, DATA: begin
          if (bus.mem_ready || wait_expired) begin
            // A timed-out transaction completes with zero data and an error flag.
            if (state_q == INST) begin
              inst_rdata_q <= bus.mem_ready ? bus.mem_rdata : 32'd0;
              inst_ok_q    <= 1'b1;
            end else begin
              data_rdata_q <= bus.mem_ready ? bus.mem_rdata : 32'd0;
              data_ok_q    <= 1'b1;
            end
            bus_err_q <= ~bus.mem_ready;
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_sel    = sel_q;
  assign bus.mem_addr   = {addr_q, 2'b00};
  assign bus.mem_wdata  = wdata_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.inst_ok    = inst_ok_q;
  assign bus.data_ok    = data_ok_q;
  assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios, then random traffic
// against a transaction-level model of the requesters and a latency-programmable memory.
module tb_mem_bus_arbiter;
  localparam int WAIT_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_inst_q[$];
  resp_t       exp_data_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;

  logic [31:0] mem_img [logic [31:0]];
  int          lat_tab [logic [31:0]];

  bit          pend_inst = 1'b0;
  bit          pend_data = 1'b0;
  logic [31:0] pi_addr, pd_addr, pd_wdata;
  logic [3:0]  pd_sel;
  int          inst_oks = 0;
  int          data_oks = 0;
  int          req_cycles = 0;
  int          stray_cnt = 0;
  int          stray_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Memory latency in wait cycles before mem_ready; default taken from address bits [7:4].
  function automatic int lat_of(input logic [31:0] a);
    if (lat_tab.exists(a)) return lat_tab[a];
    return int'(a[7:4]);
  endfunction

  function automatic resp_t expect_resp(input logic [31:0] a);
    resp_t r;
    if (lat_of(align(a)) > WAIT_MAX) begin
      r.rdata = 32'd0;
      r.err   = 1'b1;
    end else begin
      r.rdata = mem_word(align(a));
      r.err   = 1'b0;
    end
    return r;
  endfunction

  task automatic issue_inst(input logic [31:0] a);
    bus.inst_addr = a;
    bus.inst_req  = 1'b1;
    pend_inst     = 1'b1;
    pi_addr       = a;
    exp_inst_q.push_back(expect_resp(a));
  endtask

  task automatic issue_data(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    bus.data_addr  = a;
    bus.data_sel   = s;
    bus.data_wdata = w;
    bus.data_req   = 1'b1;
    pend_data      = 1'b1;
    pd_addr        = a;
    pd_sel         = s;
    pd_wdata       = w;
    exp_data_q.push_back(expect_resp(a));
  endtask

  // One negedge: requesters drop their request once they see their ok.
  task automatic tick();
    @(negedge clk);
    if (bus.mem_req) req_cycles++;
    if (bus.inst_ok) begin
      bus.inst_req = 1'b0;
      pend_inst    = 1'b0;
      inst_oks++;
    end
    if (bus.data_ok) begin
      bus.data_req = 1'b0;
      pend_data    = 1'b0;
      data_oks++;
    end
  endtask

  task automatic wait_port(input bit is_data, input int maxc, output int cyc);
    int  start;
    bit  seen;
    start = is_data ? data_oks : inst_oks;
    seen  = 1'b0;
    cyc   = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      cyc++;
      seen = ((is_data ? data_oks : inst_oks) != start);
    end
    check(is_data ? "wait_data_ok" : "wait_inst_ok", 32'(seen), 32'd1);
  endtask

  // Memory responder: checks the request it is handed and answers after the programmed latency.
  initial begin
    int          k;
    bit          prev_req;
    bit          chk_wd;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    k = 0; prev_req = 1'b0; chk_wd = 1'b0; ea = '0; ew = '0; es = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        prev_req = 1'b0;
      end else if (bus.mem_req) begin
        if (!prev_req) begin
          k = 0;
          check("grant_without_req", 32'(!pend_data && !pend_inst), 32'd0);
          if (pend_data) begin
            ea = align(pd_addr); es = pd_sel; ew = pd_wdata; chk_wd = 1'b1;
          end else begin
            ea = align(pi_addr); es = 4'd0; ew = 32'd0; chk_wd = 1'b0;
          end
        end else begin
          k++;
        end
        check("mem_addr", bus.mem_addr, ea);
        check("mem_sel", 32'(bus.mem_sel), 32'(es));
        if (chk_wd) check("mem_wdata", bus.mem_wdata, ew);
        bus.mem_rdata = mem_word(bus.mem_addr);
        bus.mem_ready = (k == lat_of(bus.mem_addr));
        prev_req = 1'b1;
      end else begin
        prev_req = 1'b0;
        if (stray_done < stray_cnt) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = 32'hDEAD_BEEF;
          stray_done++;
        end else begin
          bus.mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: every ok pulse pops the expected response for its port.
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("both_ok", 32'(bus.inst_ok & bus.data_ok), 32'd0);
        check("unexp_inst_ok", 32'(bus.inst_ok && exp_inst_q.size() == 0), 32'd0);
        check("unexp_data_ok", 32'(bus.data_ok && exp_data_q.size() == 0), 32'd0);
        check("lone_bus_err", 32'(bus.bus_err & ~bus.inst_ok & ~bus.data_ok), 32'd0);
        if (bus.inst_ok && exp_inst_q.size() != 0) begin
          r = exp_inst_q.pop_front();
          check("inst_rdata", bus.inst_rdata, r.rdata);
          check("inst_err", 32'(bus.bus_err), 32'(r.err));
        end
        if (bus.data_ok && exp_data_q.size() != 0) begin
          r = exp_data_q.pop_front();
          check("data_rdata", bus.data_rdata, r.rdata);
          check("data_err", 32'(bus.bus_err), 32'(r.err));
        end
      end
    end
  end

  initial begin
    int          cyc;
    int          ib;
    logic [31:0] sv_i, sv_d, rnd;
    logic [3:0]  lat4;

    rst = 1'b1;
    bus.inst_req = 1'b0; bus.inst_addr = '0;
    bus.data_req = 1'b0; bus.data_sel = '0; bus.data_addr = '0; bus.data_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_sel", 32'(bus.mem_sel), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_inst_rdata", bus.inst_rdata, 32'd0);
    check("rst_data_rdata", bus.data_rdata, 32'd0);
    check("rst_inst_ok", 32'(bus.inst_ok), 32'd0);
    check("rst_data_ok", 32'(bus.data_ok), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    rst = 1'b0;
    tick();

    // Idle fetch with single-cycle memory.
    mem_img[32'h0000_1004] = 32'h2402_0005;
    issue_inst(32'h0000_1006);
    req_cycles = 0;
    tick();
    check("fetch_mem_req", 32'(bus.mem_req), 32'd1);
    check("fetch_mem_addr", bus.mem_addr, 32'h0000_1004);
    check("fetch_mem_sel", 32'(bus.mem_sel), 32'd0);
    wait_port(1'b0, 20, cyc);
    check("fetch_latency", 32'(cyc), 32'd1);
    check("fetch_req_cycles", 32'(req_cycles), 32'd1);
    check("fetch_rdata_val", bus.inst_rdata, 32'h2402_0005);
    tick();
    check("fetch_ok_one_cycle", 32'(bus.inst_ok), 32'd0);

    // Contention: data wins, fetch follows.
    tick();
    ib = inst_oks;
    issue_data(32'h0000_2020, 4'b0000, 32'd0);
    issue_inst(32'h0000_3000);
    wait_port(1'b1, 30, cyc);
    check("contention_data_first", 32'(inst_oks - ib), 32'd0);
    wait_port(1'b0, 30, cyc);

    // Store with a three-cycle memory wait.
    tick();
    lat_tab[32'h0000_0010] = 3;
    req_cycles = 0;
    issue_data(32'h0000_0010, 4'b0100, 32'hABAB_ABAB);
    tick();
    check("store_mem_sel", 32'(bus.mem_sel), 32'h4);
    check("store_mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    wait_port(1'b1, 30, cyc);
    check("store_req_cycles", 32'(req_cycles), 32'd4);

    // Timeout: memory never answers.
    tick();
    lat_tab[32'h0000_0044] = 15;
    req_cycles = 0;
    issue_data(32'h0000_0044, 4'b0000, 32'd0);
    wait_port(1'b1, 30, cyc);
    check("timeout_req_cycles", 32'(req_cycles), 32'd5);
    check("timeout_rdata", bus.data_rdata, 32'd0);

    // Stray mem_ready while idle.
    repeat (2) tick();
    sv_i = bus.inst_rdata;
    sv_d = bus.data_rdata;
    stray_cnt++;
    repeat (4) tick();
    check("stray_done", 32'(stray_done), 32'(stray_cnt));
    check("stray_inst_rdata", bus.inst_rdata, sv_i);
    check("stray_data_rdata", bus.data_rdata, sv_d);

    // Fetch requester drops its request right after the grant.
    lat_tab[32'h0000_5008] = 2;
    issue_inst(32'h0000_5008);
    tick();
    bus.inst_req = 1'b0;
    wait_port(1'b0, 30, cyc);

    // Reset during a data wait with a fetch queued behind it.
    tick();
    lat_tab[32'h0000_6000] = 15;
    issue_data(32'h0000_6000, 4'b0000, 32'd0);
    repeat (2) tick();
    issue_inst(32'h0000_7000);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_inst_rdata", bus.inst_rdata, 32'd0);
    check("midrst_data_rdata", bus.data_rdata, 32'd0);
    exp_data_q.delete();
    pend_data    = 1'b0;
    bus.data_req = 1'b0;
    ib = data_oks;
    repeat (3) tick();
    check("midrst_no_data_ok", 32'(data_oks - ib), 32'd0);
    rst = 1'b0;
    wait_port(1'b0, 30, cyc);
    check("postrst_grant_latency", 32'(cyc), 32'd2);

    // Random traffic from both requesters.
    lat_tab.delete();
    mem_img.delete();
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (!pend_inst && !bus.inst_req && $urandom_range(0, 3) == 0) begin
        rnd  = $urandom();
        lat4 = 4'($urandom_range(0, 6));
        issue_inst({rnd[31:8], lat4, rnd[3:0]});
      end
      if (!pend_data && !bus.data_req && $urandom_range(0, 3) == 0) begin
        rnd  = $urandom();
        lat4 = 4'($urandom_range(0, 6));
        issue_data({rnd[31:8], lat4, rnd[3:0]},
                   ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                   $urandom());
      end
    end
    for (int n = 0; n < 200 && (pend_inst || pend_data); n++) tick();
    repeat (2) tick();
    check("drain_pending", 32'({pend_inst, pend_data}), 32'd0);
    check("drain_inst_queue", 32'(exp_inst_q.size()), 32'd0);
    check("drain_data_queue", 32'(exp_data_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum memory-wait cycles per transaction before timeout (legal range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inst_req  input  1  fetch request, level, held high until inst_ok.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_rdata  output  32  fetched word.
REQ-007 inst_ok  output  1  one-cycle fetch completion pulse.
REQ-008 data_req  input  1  load/store request, level, held high until data_ok.
REQ-009 data_sel  input  4  byte write strobes; 4'b0000 = load.
REQ-010 data_addr  input  32  load/store byte address.
REQ-011 data_wdata  input  32  store data, already lane-replicated.
REQ-012 data_rdata  output  32  loaded raw word, before lane extraction.
REQ-013 data_ok  output  1  one-cycle load/store completion pulse.
REQ-014 mem_req  output  1  shared memory request, level.
REQ-015 mem_sel  output  4  byte write strobes to memory.
REQ-016 mem_addr  output  32  word-aligned memory address ({addr[31:2],2'b00}).
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid in the mem_ready cycle.
REQ-019 mem_ready  input  1  memory completion, one cycle, ignored unless mem_req=1.
REQ-020 bus_err  output  1  one-cycle pulse with inst_ok/data_ok when a transaction timed out.

Function
REQ-021 States: IDLE, INST, DATA, RESP; the FSM SHALL occupy exactly one state.
REQ-022 IDLE: data_req=1 -> DATA (data priority, even if inst_req=1); else inst_req=1 -> INST; else stay IDLE.
REQ-023 On a grant, the block SHALL latch addr, sel and wdata of the winner into registers; mem_* outputs SHALL be driven only from these registers.
REQ-024 mem_req SHALL be 1 in INST and DATA and 0 in IDLE and RESP; for INST, mem_sel SHALL be 4'b0000.
REQ-025 In INST/DATA, a cycle with mem_ready=1 SHALL capture mem_rdata into inst_rdata or data_rdata respectively and go to RESP.
REQ-026 A wait counter SHALL clear on grant and increment in each INST/DATA cycle with mem_ready=0; when it equals WAIT_MAX with mem_ready=0, the FSM SHALL go to RESP with the timeout flag set and the read data register loaded with 32'h0.
REQ-027 RESP SHALL last exactly one cycle, pulse the matching ok (and bus_err if timeout) and return to IDLE; the ok/err pulses SHALL be registered outputs.
REQ-028 Minimum latency: request seen in IDLE at cycle N, mem_ready at N+1, ok pulse at N+2; the next grant is no earlier than N+3.
REQ-029 inst_rdata/data_rdata SHALL hold their value until the next completion of the same port.
REQ-030 Stores (data_sel!=0) SHALL also return data_ok; data_rdata SHALL then be updated with mem_rdata.
REQ-031 A requester that drops its req before ok SHALL NOT abort the transaction; completion still pulses ok.
REQ-032 inst_ok and data_ok SHALL never be 1 in the same cycle.
REQ-033 A mem_ready pulse in IDLE or RESP SHALL be ignored.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, counter=0, mem_req=0, mem_sel=0, mem_addr=0, mem_wdata=0, inst_rdata=0, data_rdata=0, inst_ok=0, data_ok=0, bus_err=0.
REQ-035 Reset mid-transaction SHALL abandon it with no ok pulse; the first grant after deassertion follows REQ-022.

Verification
REQ-036 Idle fetch: inst_req=1, inst_addr=32'h0000_1006, mem_ready on the next cycle with mem_rdata=32'h2402_0005 -> mem_addr=32'h0000_1004, mem_sel=0, then inst_ok=1 for one cycle, inst_rdata=32'h2402_0005.
REQ-037 Contention: inst_req and data_req both rise in the same cycle -> data transaction is served first, data_ok pulses, then the fetch is served, inst_ok pulses; no cycle has both ok pulses.
REQ-038 Store: data_sel=4'b0100, data_addr=32'h10, data_wdata=32'hABAB_ABAB, mem_ready after 3 cycles -> mem_sel=4'b0100, mem_addr=32'h10, mem_wdata=32'hABAB_ABAB held for the whole wait, then one data_ok.
REQ-039 Timeout: WAIT_MAX=4, mem_ready never asserted -> mem_req high for 5 cycles, then data_ok=1, bus_err=1, data_rdata=0.
REQ-040 Reset during the wait of a data transaction -> mem_req=0 in the same cycle, no data_ok, and a pending inst_req is granted after rst deasserts.
REQ-041 Stray mem_ready in IDLE -> no ok pulse and no change to the read data registers.
